// File: rtl/life_color_pkg.sv
// Shared constants and helpers for the Life cell colouring datapath.
package life_color_pkg;

  localparam int unsigned HUE_SECTORS = 12;
  localparam int unsigned SAT_MIN     = 4;
  localparam int unsigned V_MAX       = 7;
  localparam int unsigned FADE_FLOOR  = 1;
  // A freshly dead cell starts one step below full brightness.
  localparam int unsigned FADE_TOP    = 6;

  localparam int unsigned HUE_W = 4;
  localparam int unsigned SAT_W = 3;
  localparam int unsigned VAL_W = 3;

  // RGB332 field widths.
  localparam int unsigned R_W     = 3;
  localparam int unsigned G_W     = 3;
  localparam int unsigned B_W     = 2;
  localparam int unsigned COLOR_W = R_W + G_W + B_W;

  // Sector membership masks, bit n set means hue sector n belongs to the set.
  localparam logic [HUE_SECTORS-1:0] R_MAX_SET = 12'b1100_0000_0111; // 0,1,2,10,11
  localparam logic [HUE_SECTORS-1:0] R_MID_SET = 12'b0010_0000_1000; // 3,9
  localparam logic [HUE_SECTORS-1:0] G_MAX_SET = 12'b0000_0111_1100; // 2..6
  localparam logic [HUE_SECTORS-1:0] G_MID_SET = 12'b0000_1000_0010; // 1,7
  localparam logic [HUE_SECTORS-1:0] B_MAX_SET = 12'b0111_1100_0000; // 6..10
  localparam logic [HUE_SECTORS-1:0] B_MID_SET = 12'b1000_0010_0000; // 5,11

  // Select max/mid/min level for one channel given its sector sets.
  function automatic logic [VAL_W-1:0] sector_pick(
    input logic [HUE_SECTORS-1:0] max_set,
    input logic [HUE_SECTORS-1:0] mid_set,
    input logic [HUE_W-1:0]       hue,
    input logic [VAL_W-1:0]       v_max,
    input logic [VAL_W-1:0]       v_mid,
    input logic [VAL_W-1:0]       v_min
  );
    if (max_set[hue]) begin
      return v_max;
    end else if (mid_set[hue]) begin
      return v_mid;
    end
    return v_min;
  endfunction

endpackage

// File: rtl/hsv12_to_rgb332.sv
// Combinational 12-sector HSV to RGB332 converter.
module hsv12_to_rgb332 import life_color_pkg::*; (
  input  logic [HUE_W-1:0]   hue,
  input  logic [SAT_W-1:0]   sat,
  input  logic [VAL_W-1:0]   val,
  output logic [COLOR_W-1:0] color
);

  logic [5:0]       prod;
  logic [VAL_W-1:0] t;
  logic [VAL_W-1:0] v_min;
  logic [VAL_W-1:0] v_mid;
  logic [VAL_W-1:0] r;
  logic [VAL_W-1:0] g;
  logic [VAL_W-1:0] b3;
  logic [B_W-1:0]   b;

  // Derive min/mid levels from v and s, then pick per-channel level by sector.
  always_comb begin
    prod  = {3'b000, val} * {3'b000, sat};
    // v*s <= 49, so the quotient never exceeds 7.
    t     = VAL_W'(prod / 6'd7);
    v_min = val - t;
    v_mid = val - {1'b0, t[2:1]};
    r     = sector_pick(R_MAX_SET, R_MID_SET, hue, val, v_mid, v_min);
    g     = sector_pick(G_MAX_SET, G_MID_SET, hue, val, v_mid, v_min);
    b3    = sector_pick(B_MAX_SET, B_MID_SET, hue, val, v_mid, v_min);
    b     = B_W'(b3 >> 1);
    color = {r, g, b};
  end

endmodule

// File: rtl/cell_color_pipeline.sv
// Three-stage valid/ready pipeline turning cell descriptors into RGB332 colours.
module cell_color_pipeline import life_color_pkg::*; #(
  parameter int unsigned GRID_W  = 32,
  parameter int unsigned GRID_H  = 32,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned AGE_W   = 4,
  parameter int unsigned HUE_INC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IDX_W-1:0]   x_index,
  input  logic [IDX_W-1:0]   y_index,
  input  logic               alive,
  input  logic [AGE_W-1:0]   age,
  input  logic               mode,
  input  logic               rotate_en,
  input  logic               gen_tick,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COLOR_W-1:0] color,
  output logic [HUE_W-1:0]   hue_offset
);

  logic adv;

  logic [4:0]       hue_sum;
  logic [HUE_W-1:0] hue_new;
  logic [SAT_W-1:0] sat_new;
  logic [4:0]       step_sum;
  logic [HUE_W-1:0] hue_offset_d;

  logic             s1_valid_q;
  logic [HUE_W-1:0] s1_hue_q;
  logic [SAT_W-1:0] s1_sat_q;
  logic             s1_alive_q;
  logic [AGE_W-1:0] s1_age_q;
  logic             s1_mode_q;

  logic [VAL_W-1:0] val_new;

  logic             s2_valid_q;
  logic [HUE_W-1:0] s2_hue_q;
  logic [SAT_W-1:0] s2_sat_q;
  logic [VAL_W-1:0] s2_val_q;

  logic [COLOR_W-1:0] color_new;

  // Whole pipe moves as one unit whenever the output slot is free or draining.
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
  end

  // Stage-1 hue/saturation from the cell position; 32-bit math avoids truncation.
  always_comb begin
    hue_sum = 5'((32'(x_index) * HUE_SECTORS) / GRID_W) + 5'(hue_offset);
    hue_new = (hue_sum >= 5'(HUE_SECTORS)) ? HUE_W'(hue_sum - 5'(HUE_SECTORS))
                                           : hue_sum[HUE_W-1:0];
    sat_new = SAT_W'(SAT_MIN + (32'(y_index) * 4) / GRID_H);
  end

  // Stage-2 brightness: alive is full, dead is black or fades with age.
  always_comb begin
    val_new = '0;
    if (s1_alive_q) begin
      val_new = VAL_W'(V_MAX);
    end else if (s1_mode_q) begin
      if (s1_age_q < AGE_W'(FADE_TOP)) begin
        val_new = VAL_W'(AGE_W'(FADE_TOP) - s1_age_q);
      end else begin
        val_new = VAL_W'(FADE_FLOOR);
      end
    end
  end

  // Next hue offset, wrapping modulo the sector count.
  always_comb begin
    step_sum     = 5'(hue_offset) + 5'(HUE_INC);
    hue_offset_d = hue_offset;
    if (gen_tick && rotate_en) begin
      hue_offset_d = (step_sum >= 5'(HUE_SECTORS)) ? HUE_W'(step_sum - 5'(HUE_SECTORS))
                                                   : step_sum[HUE_W-1:0];
    end
  end

  hsv12_to_rgb332 u_hsv (
    .hue   (s2_hue_q),
    .sat   (s2_sat_q),
    .val   (s2_val_q),
    .color (color_new)
  );

  // Hue rotation runs regardless of pipeline stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      hue_offset <= '0;
    end else begin
      hue_offset <= hue_offset_d;
    end
  end

  // Pipeline registers: all stages shift together on adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_hue_q   <= '0;
      s1_sat_q   <= '0;
      s1_alive_q <= 1'b0;
      s1_age_q   <= '0;
      s1_mode_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_hue_q   <= '0;
      s2_sat_q   <= '0;
      s2_val_q   <= '0;
      out_valid  <= 1'b0;
      color      <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_hue_q   <= hue_new;
      s1_sat_q   <= sat_new;
      s1_alive_q <= alive;
      s1_age_q   <= age;
      s1_mode_q  <= mode;
      s2_valid_q <= s1_valid_q;
      s2_hue_q   <= s1_hue_q;
      s2_sat_q   <= s1_sat_q;
      s2_val_q   <= val_new;
      out_valid  <= s2_valid_q;
      color      <= color_new;
    end
  end

endmodule
